// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: fetch FSM state encodings and word geometry shared by the fetch stage.
package if_fetch_pkg;
  typedef enum logic [2:0] {
    FS_B0   = 3'd0,
    FS_B1   = 3'd1,
    FS_B2   = 3'd2,
    FS_B3   = 3'd3,
    FS_HOLD = 3'd4
  } fs_e;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: owns the PC and assembles each 32-bit instruction from four little-endian byte reads.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        misalign_o
);
  fs_e state_q, state_d;
  logic [31:0] fpc_q, fpc_d, pc_q, pc_d, inst_q, inst_d;
  logic [INST_BYTES-1:0][7:0] asm_q, asm_d;
  logic mis_q, mis_d;
  logic [1:0] idx;
  logic ack;
  // Byte states are encoded 0..3 so the low state bits double as the byte index.
  assign idx = state_q[1:0];
  assign ack = mem_ack_i & mem_req_o;
  always_comb begin
    state_d = state_q;
    fpc_d = fpc_q;
    pc_d = pc_q;
    inst_d = inst_q;
    asm_d = asm_q;
    mis_d = jump_i & |jump_addr_i[1:0];
    if (jump_i) begin
      state_d = FS_B0;
      fpc_d = {jump_addr_i[31:2], 2'b00};
    end else if (state_q == FS_HOLD) begin
      if (!stall_i) begin
        state_d = FS_B0;
        fpc_d = fpc_q + PC_STEP;
      end
    end else if (ack) begin
      asm_d[idx] = mem_data_i;
      state_d = fs_e'(state_q + 3'd1);
      if (state_q == FS_B3) begin
        pc_d = fpc_q;
        inst_d = asm_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_B0;
      fpc_q <= RESET_PC;
      pc_q <= '0;
      inst_q <= '0;
      asm_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      asm_q <= asm_d;
      mis_q <= mis_d;
    end
  end
  assign mem_req_o = !rst && state_q != FS_HOLD;
  assign mem_addr_o = mem_req_o ? fpc_q + {30'd0, idx} : '0;
  assign pc_o = pc_q;
  assign inst_o = inst_q;
  assign inst_valid_o = state_q == FS_HOLD;
  assign misalign_o = mis_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed fetch scenarios with a transfer scoreboard and a byte memory responder.
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst, stall_i, jump_i, mem_req_o, mem_ack_i, inst_valid_o, misalign_o;
  logic [31:0] jump_addr_i, mem_addr_o, pc_o, inst_o;
  logic [7:0] mem_data_i;
  int checks = 0, errors = 0, wait_n = 0;
  logic [63:0] sb[$];

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory image: bytes 13 00 00 00 at 0..3, addr[7:0]^5A elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a < 32'd4) ? ((a == 32'd0) ? 8'h13 : 8'h00) : (lo ^ 8'h5A);
  endfunction

  initial begin
    int cnt;
    logic [31:0] last;
    cnt = 0;
    last = '1;
    mem_ack_i = 1'b0;
    mem_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req_o !== 1'b1) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else begin
        if (mem_addr_o != last) cnt = 0;
        last = mem_addr_o;
        mem_ack_i = (cnt == wait_n);
        mem_data_i = mb(mem_addr_o);
        cnt = mem_ack_i ? 0 : cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && inst_valid_o === 1'b1 && stall_i === 1'b0 && jump_i === 1'b0) begin
      if (sb.size() == 0) chk("xfer_unexpected", pc_o, 32'hDEAD_BEEF);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("xfer_pc", pc_o, e[63:32]);
        chk("xfer_inst", inst_o, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
    tick(); tick();
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    // T1: first word from reset, zero-wait memory
    rst = 1'b0; #1;
    chk("t1_req", {31'd0, mem_req_o}, 32'd1);
    chk("t1_addr0", mem_addr_o, 32'd0);
    sb.push_back({32'h0, 32'h0000_0013});
    tick(); chk("t1_addr1", mem_addr_o, 32'd1);
    tick(); chk("t1_addr2", mem_addr_o, 32'd2);
    tick(); chk("t1_addr3", mem_addr_o, 32'd3);
    stall_i = 1'b1;
    tick();
    chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("t1_pc", pc_o, 32'd0);
    chk("t1_inst", inst_o, 32'h0000_0013);
    // T2: held under stall, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("t2_hold_inst", inst_o, 32'h0000_0013);
      chk("t2_hold_req", {31'd0, mem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    chk("t2_next_addr", mem_addr_o, 32'd4);
    chk("t2_next_req", {31'd0, mem_req_o}, 32'd1);
    chk("t2_valid_drop", {31'd0, inst_valid_o}, 32'd0);
    sb.push_back({32'h4, 32'h5D5C_5F5E});
    tick(); tick(); tick(); tick();
    chk("t2_pc4", pc_o, 32'd4);
    tick(); chk("t3_b0", mem_addr_o, 32'd8);
    // T3: aligned redirect during B2
    tick(); tick();
    chk("t3_b2", mem_addr_o, 32'd10);
    jump_i = 1'b1; jump_addr_i = 32'h100;
    tick(); jump_i = 1'b0;
    chk("t3_target", mem_addr_o, 32'h100);
    chk("t3_no_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("t3_no_mis", {31'd0, misalign_o}, 32'd0);
    sb.push_back({32'h100, 32'h5958_5B5A});
    tick(); tick(); tick(); tick();
    chk("t3_pc", pc_o, 32'h100);
    tick(); chk("t4_b0", mem_addr_o, 32'h104);
    // T4: misaligned redirect
    jump_i = 1'b1; jump_addr_i = 32'h102;
    tick(); jump_i = 1'b0;
    chk("t4_mis", {31'd0, misalign_o}, 32'd1);
    chk("t4_target", mem_addr_o, 32'h100);
    sb.push_back({32'h100, 32'h5958_5B5A});
    tick();
    chk("t4_mis_pulse", {31'd0, misalign_o}, 32'd0);
    chk("t4_addr1", mem_addr_o, 32'h101);
    tick(); tick(); tick();
    chk("t4_valid", {31'd0, inst_valid_o}, 32'd1);
    // T5: two wait cycles per byte
    wait_n = 2;
    sb.push_back({32'h104, 32'h5D5C_5F5E});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inst_valid_o) break;
      if (mem_req_o) n++;
    end
    wait_n = 0;
    chk("t5_latency", n, 32'd12);
    chk("t5_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("t5_inst", inst_o, 32'h5D5C_5F5E);
    // T6: PC wrap, then reset mid-fetch
    tick();
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick(); jump_i = 1'b0;
    chk("t6_target", mem_addr_o, 32'hFFFF_FFFC);
    sb.push_back({32'hFFFF_FFFC, 32'hA5A4_A7A6});
    tick(); tick(); tick(); tick();
    chk("t6_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap", mem_addr_o, 32'h0);
    jump_i = 1'b1; jump_addr_i = 32'h200;
    tick(); jump_i = 1'b0;
    chk("t6_jump200", mem_addr_o, 32'h200);
    tick();
    chk("t6_b1", mem_addr_o, 32'h201);
    rst = 1'b1;
    tick();
    chk("t6_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("t6_rst_pc", pc_o, 32'd0);
    rst = 1'b0; #1;
    chk("t6_restart", mem_addr_o, 32'h0);
    chk("t6_restart_req", {31'd0, mem_req_o}, 32'd1);
    sb.push_back({32'h0, 32'h0000_0013});
    tick(); tick(); tick(); tick();
    chk("t6_inst", inst_o, 32'h0000_0013);
    tick(); tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
